// File: rtl/argmax_pkg.sv
// Shared types and elaboration helpers for the argmax/argmin compare tree.
package argmax_pkg;

  typedef enum logic {ARGMAX_MODE_MAX = 1'b0, ARGMAX_MODE_MIN = 1'b1} argmax_mode_e;

  // Number of registered compare levels for a power-of-two candidate count.
  function automatic int argmax_levels(input int num_entries);
    return $clog2(num_entries);
  endfunction

  // Depth of node i in a heap-ordered tree (root = 0, children of i are 2i+1, 2i+2).
  function automatic int argmax_node_depth(input int i);
    return $clog2(i + 2) - 1;
  endfunction

endpackage

// File: rtl/argmax_node.sv
// Combinational max/min select of two tagged candidates; lower index wins ties.
// Latency: 0 cycles (pure logic, registered by argmax_tree).
// Backpressure: none; optional equal-value count path under ARGMAX_TREE_TIECOUNT_EN.
module argmax_node
  import argmax_pkg::*;
#(
  parameter int VALUE_WIDTH = 32,
  parameter int INDEX_WIDTH = 3
) (
  input  argmax_mode_e           mode,
  input  logic [VALUE_WIDTH-1:0] l_val,
  input  logic [INDEX_WIDTH-1:0] l_idx,
  input  logic                   l_pres,
  input  logic [VALUE_WIDTH-1:0] r_val,
  input  logic [INDEX_WIDTH-1:0] r_idx,
  input  logic                   r_pres,
`ifdef ARGMAX_TREE_TIECOUNT_EN
  input  logic [INDEX_WIDTH:0]   l_cnt,
  input  logic [INDEX_WIDTH:0]   r_cnt,
  output logic [INDEX_WIDTH:0]   win_cnt,
`endif
  output logic [VALUE_WIDTH-1:0] win_val,
  output logic [INDEX_WIDTH-1:0] win_idx,
  output logic                   win_pres
);

  logic r_better;
  logic take_r;

  always_comb begin
    r_better = (mode == ARGMAX_MODE_MAX) ? (r_val > l_val) : (r_val < l_val);
    // R wins only when it is alone or strictly better; otherwise L (also when neither is present).
    take_r   = r_pres & (~l_pres | r_better);
    win_val  = take_r ? r_val : l_val;
    win_idx  = take_r ? r_idx : l_idx;
    win_pres = l_pres | r_pres;
  end

`ifdef ARGMAX_TREE_TIECOUNT_EN
  always_comb begin
    if (l_pres && r_pres && (l_val == r_val)) begin
      win_cnt = l_cnt + r_cnt;
    end else begin
      win_cnt = take_r ? r_cnt : l_cnt;
    end
  end
`endif

endmodule

// File: rtl/argmax_tree.sv
// Pipelined argmax/argmin over NUM_ENTRIES masked candidates; optional tie_count_o via ARGMAX_TREE_TIECOUNT_EN.
// Latency: request accepted at edge t is presented after edge t+LEVELS (input capture + LEVELS compare levels).
// Backpressure: ready_o = ~valid_o | ready_i; a held result freezes every stage.
module argmax_tree
  import argmax_pkg::*;
#(
  parameter  int NUM_ENTRIES = 8,
  parameter  int VALUE_WIDTH = 32,
  localparam int INDEX_WIDTH = argmax_levels(NUM_ENTRIES)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [NUM_ENTRIES*VALUE_WIDTH-1:0] values_i,
  input  logic [NUM_ENTRIES-1:0]           mask_i,
  input  logic                             mode_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  output logic [VALUE_WIDTH-1:0]           value_o,
  output logic [INDEX_WIDTH-1:0]           index_o,
  output logic                             found_o,
`ifdef ARGMAX_TREE_TIECOUNT_EN
  output logic [INDEX_WIDTH:0]             tie_count_o,
`endif
  output logic                             valid_o,
  input  logic                             ready_i
);

  localparam int LEVELS = argmax_levels(NUM_ENTRIES);
  localparam int NODES  = NUM_ENTRIES - 1;
  localparam int KIDS   = 2 * NUM_ENTRIES - 2;

  logic                             advance;
  logic [LEVELS:0]                  vld_q;
  logic [LEVELS-1:0]                mode_q;
  logic [NUM_ENTRIES*VALUE_WIDTH-1:0] in_val_q;
  logic [NUM_ENTRIES-1:0]           in_mask_q;

  // Heap-ordered node registers: node 0 is the root / output stage.
  logic [VALUE_WIDTH-1:0] node_val_q  [NODES];
  logic [INDEX_WIDTH-1:0] node_idx_q  [NODES];
  logic                   node_pres_q [NODES];
  logic [VALUE_WIDTH-1:0] nxt_val     [NODES];
  logic [INDEX_WIDTH-1:0] nxt_idx     [NODES];
  logic                   nxt_pres    [NODES];

  // kid[j] is tree node j+1: registered internal nodes first, then the captured leaves.
  logic [VALUE_WIDTH-1:0] kid_val  [KIDS];
  logic [INDEX_WIDTH-1:0] kid_idx  [KIDS];
  logic                   kid_pres [KIDS];

`ifdef ARGMAX_TREE_TIECOUNT_EN
  logic [INDEX_WIDTH:0]   node_cnt_q [NODES];
  logic [INDEX_WIDTH:0]   nxt_cnt    [NODES];
  logic [INDEX_WIDTH:0]   kid_cnt    [KIDS];
`endif

  assign valid_o = vld_q[LEVELS];
  assign ready_o = ~valid_o | ready_i;
  assign advance = ready_o;

  assign value_o = node_val_q[0];
  assign index_o = node_idx_q[0];
  assign found_o = node_pres_q[0];
`ifdef ARGMAX_TREE_TIECOUNT_EN
  assign tie_count_o = node_cnt_q[0];
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      vld_q     <= '0;
      mode_q    <= '0;
      in_val_q  <= '0;
      in_mask_q <= '0;
    end else if (advance) begin
      vld_q <= {vld_q[LEVELS-1:0], valid_i};
      for (int s = 1; s < LEVELS; s++) begin
        mode_q[s] <= mode_q[s-1];
      end
      if (valid_i) begin
        mode_q[0] <= mode_i;
        in_val_q  <= values_i;
        in_mask_q <= mask_i;
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NODES - 1; j++) begin
      kid_val[j]  = node_val_q[j+1];
      kid_idx[j]  = node_idx_q[j+1];
      kid_pres[j] = node_pres_q[j+1];
`ifdef ARGMAX_TREE_TIECOUNT_EN
      kid_cnt[j]  = node_cnt_q[j+1];
`endif
    end
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      kid_val[NODES-1+k]  = in_val_q[k*VALUE_WIDTH +: VALUE_WIDTH];
      kid_idx[NODES-1+k]  = INDEX_WIDTH'(k);
      kid_pres[NODES-1+k] = in_mask_q[k];
`ifdef ARGMAX_TREE_TIECOUNT_EN
      kid_cnt[NODES-1+k]  = {{INDEX_WIDTH{1'b0}}, in_mask_q[k]};
`endif
    end
  end

  for (genvar i = 0; i < NODES; i++) begin : g_node
    // A node at depth D consumes the stage whose mode sits in mode_q[LEVELS-1-D].
    localparam int DEPTH = argmax_node_depth(i);

    argmax_node #(
      .VALUE_WIDTH (VALUE_WIDTH),
      .INDEX_WIDTH (INDEX_WIDTH)
    ) u_node (
      .mode     (argmax_mode_e'(mode_q[LEVELS-1-DEPTH])),
      .l_val    (kid_val[2*i]),
      .l_idx    (kid_idx[2*i]),
      .l_pres   (kid_pres[2*i]),
      .r_val    (kid_val[2*i+1]),
      .r_idx    (kid_idx[2*i+1]),
      .r_pres   (kid_pres[2*i+1]),
`ifdef ARGMAX_TREE_TIECOUNT_EN
      .l_cnt    (kid_cnt[2*i]),
      .r_cnt    (kid_cnt[2*i+1]),
      .win_cnt  (nxt_cnt[i]),
`endif
      .win_val  (nxt_val[i]),
      .win_idx  (nxt_idx[i]),
      .win_pres (nxt_pres[i])
    );
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < NODES; i++) begin
        node_val_q[i]  <= '0;
        node_idx_q[i]  <= '0;
        node_pres_q[i] <= 1'b0;
`ifdef ARGMAX_TREE_TIECOUNT_EN
        node_cnt_q[i]  <= '0;
`endif
      end
    end else if (advance) begin
      for (int i = 1; i < NODES; i++) begin
        node_val_q[i]  <= nxt_val[i];
        node_idx_q[i]  <= nxt_idx[i];
        node_pres_q[i] <= nxt_pres[i];
`ifdef ARGMAX_TREE_TIECOUNT_EN
        node_cnt_q[i]  <= nxt_cnt[i];
`endif
      end
      // An empty result is reported as value 0 / index 0 rather than the left-leaf don't-care.
      node_val_q[0]  <= nxt_pres[0] ? nxt_val[0] : '0;
      node_idx_q[0]  <= nxt_pres[0] ? nxt_idx[0] : '0;
      node_pres_q[0] <= nxt_pres[0];
`ifdef ARGMAX_TREE_TIECOUNT_EN
      node_cnt_q[0]  <= nxt_cnt[0];
`endif
    end
  end

endmodule

// File: tb/tb_argmax_tree.sv
// Scoreboard bench for argmax_tree: driver pushes expected results, a monitor pops on each consumed output.
`timescale 1ns/1ps
module tb_argmax_tree;

  localparam int N  = 8;
  localparam int VW = 32;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            reset_n_i;
  logic [N*VW-1:0] values_i;
  logic [N-1:0]    mask_i;
  logic            mode_i;
  logic            valid_i;
  logic            ready_o;
  logic [VW-1:0]   value_o;
  logic [IW-1:0]   index_o;
  logic            found_o;
  logic            valid_o;
  logic            ready_i;
`ifdef ARGMAX_TREE_TIECOUNT_EN
  logic [IW:0]     tie_count_o;
`endif

  always #5 clk = ~clk;

  argmax_tree #(.NUM_ENTRIES(N), .VALUE_WIDTH(VW)) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n_i),
    .values_i    (values_i),
    .mask_i      (mask_i),
    .mode_i      (mode_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .value_o     (value_o),
    .index_o     (index_o),
    .found_o     (found_o),
`ifdef ARGMAX_TREE_TIECOUNT_EN
    .tie_count_o (tie_count_o),
`endif
    .valid_o     (valid_o),
    .ready_i     (ready_i)
  );

  typedef struct packed {
    logic [VW-1:0] val;
    logic [IW-1:0] idx;
    logic          found;
    logic [IW:0]   tie;
  } exp_t;

  exp_t          exp_q[$];
  int            n_cmp  = 0;
  int            n_fail = 0;
  int            rdy_mode = 1;  // 0 = hold off, 1 = always ready, 2 = random
  logic [VW-1:0] sv [N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [VW-1:0] v, input int i, input logic f, input int t);
    exp_t r;
    r.val   = v;
    r.idx   = IW'(i);
    r.found = f;
    r.tie   = (IW+1)'(t);
    return r;
  endfunction

  // Reference: linear scan, first strictly-better masked entry wins.
  function automatic exp_t model(input logic [N-1:0] m, input logic md);
    exp_t r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      if (m[k] && (!r.found || (md ? (sv[k] < r.val) : (sv[k] > r.val)))) begin
        r.found = 1'b1;
        r.val   = sv[k];
        r.idx   = IW'(k);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (m[k] && r.found && sv[k] == r.val) r.tie = r.tie + 1'b1;
    end
    return r;
  endfunction

  initial begin
    ready_i = 1'b1;
    forever begin
      @(negedge clk);
      if (rdy_mode == 0)      ready_i = 1'b0;
      else if (rdy_mode == 1) ready_i = 1'b1;
      else                    ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n_i === 1'b1 && valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("result_without_request", valid_o, 1'b0);
        end else begin
          e = exp_q[0];
          chk("found_o", found_o, e.found);
          chk("value_o", value_o, e.val);
          chk("index_o", index_o, e.idx);
`ifdef ARGMAX_TREE_TIECOUNT_EN
          chk("tie_count_o", tie_count_o, e.tie);
`endif
          if (ready_i) e = exp_q.pop_front();
          else         chk("ready_o_during_stall", ready_o, 1'b0);
        end
      end
    end
  end

  task automatic send_core(input logic [N-1:0] m, input logic md, input bit use_exp, input exp_t ex);
    exp_t e2;
    int   guard = 0;
    @(negedge clk);
    for (int k = 0; k < N; k++) values_i[k*VW +: VW] = sv[k];
    mask_i  = m;
    mode_i  = md;
    valid_i = 1'b1;
    e2 = use_exp ? ex : model(m, md);
    #1;
    while (!ready_o && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (ready_o) exp_q.push_back(e2);
    else         chk("accept_timeout", ready_o, 1'b1);
  endtask

  task automatic send(input logic [N-1:0] m, input logic md);
    send_core(m, md, 1'b0, '0);
  endtask

  task automatic send_exp(input logic [N-1:0] m, input logic md, input exp_t ex);
    send_core(m, md, 1'b1, ex);
  endtask

  task automatic idle();
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic set_rdy(input int md);
    @(posedge clk);
    #1;
    rdy_mode = md;
  endtask

  task automatic drain();
    int g = 0;
    idle();
    set_rdy(1);
    while (exp_q.size() != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic rand_vals();
    int kind;
    kind = $urandom_range(0, 2);
    for (int k = 0; k < N; k++) begin
      case (kind)
        0:       sv[k] = $urandom;
        1:       sv[k] = VW'($urandom_range(0, 3));
        default: sv[k] = (($urandom_range(0, 2) == 0) ? 32'h0 :
                          ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE);
      endcase
    end
  endtask

  task automatic do_reset_pulse();
    @(negedge clk);
    valid_i = 1'b0;
    #3;
    reset_n_i = 1'b0;
    #1;
    chk("rst_valid_o", valid_o, 1'b0);
    chk("rst_ready_o", ready_o, 1'b1);
    chk("rst_found_o", found_o, 1'b0);
    chk("rst_value_o", value_o, '0);
    exp_q.delete();
    @(negedge clk);
    #3;
    reset_n_i = 1'b1;
  endtask

  initial begin
    logic [N-1:0] m;
    int           g;
    reset_n_i = 1'b0;
    valid_i   = 1'b0;
    values_i  = '0;
    mask_i    = '0;
    mode_i    = 1'b0;
    #1;
    chk("reset_valid_o", valid_o, 1'b0);
    chk("reset_ready_o", ready_o, 1'b1);
    chk("reset_found_o", found_o, 1'b0);
    chk("reset_value_o", value_o, '0);
    chk("reset_index_o", index_o, '0);
`ifdef ARGMAX_TREE_TIECOUNT_EN
    chk("reset_tie_count_o", tie_count_o, '0);
`endif
    repeat (3) @(negedge clk);
    #3;
    reset_n_i = 1'b1;

    // Directed vectors, back to back at full throughput.
    sv = '{32'd3, 32'd9, 32'd1, 32'd9, 32'd0, 32'd2, 32'd7, 32'd5};
    send_exp(8'hFF, 1'b0, mk(32'd9, 1, 1'b1, 2));
    send_exp(8'hEF, 1'b1, mk(32'd1, 2, 1'b1, 1));
    send_exp(8'h00, 1'b0, mk(32'd0, 0, 1'b0, 0));
    send_exp(8'h80, 1'b1, mk(32'd5, 7, 1'b1, 1));
    send_exp(8'h0A, 1'b0, mk(32'd9, 1, 1'b1, 2));
    send_exp(8'hFF, 1'b1, mk(32'd0, 4, 1'b1, 1));
    for (int k = 0; k < N; k++) sv[k] = 32'hFFFF_FFFF;
    send_exp(8'hFF, 1'b0, mk(32'hFFFF_FFFF, 0, 1'b1, 8));
    send_exp(8'hF0, 1'b1, mk(32'hFFFF_FFFF, 4, 1'b1, 4));
    drain();

    // Five back-to-back requests with the first result held for four cycles.
    set_rdy(0);
    fork
      begin
        for (int r = 0; r < 5; r++) begin
          rand_vals();
          send($urandom_range(0, 255), $urandom_range(0, 1));
        end
        idle();
      end
      begin
        g = 0;
        @(posedge clk);
        #1;
        while (!valid_o && g < 50) begin
          @(posedge clk);
          #1;
          g++;
        end
        chk("stall_first_result", valid_o, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        rdy_mode = 1;
      end
    join
    drain();

    // Reset with two requests still inside the pipeline.
    rand_vals();
    send(8'hFF, 1'b0);
    send(8'h3C, 1'b1);
    do_reset_pulse();
    repeat (8) @(negedge clk);

    // Reset while a result is being held at the output.
    set_rdy(0);
    rand_vals();
    send(8'hFF, 1'b1);
    idle();
    g = 0;
    while (!valid_o && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("held_result_present", valid_o, 1'b1);
    do_reset_pulse();
    set_rdy(1);
    repeat (8) @(negedge clk);

    // Randomized traffic with random backpressure and bubbles.
    set_rdy(2);
    for (int r = 0; r < 150; r++) begin
      rand_vals();
      case ($urandom_range(0, 7))
        0:       m = '0;
        1:       m = '1;
        default: m = N'($urandom_range(0, 255));
      endcase
      send(m, $urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) idle();
    end
    drain();

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/argmax_tree.md
Name: argmax_tree

Overview:
- Pipelined, parametrised argmax/argmin selector over NUM_ENTRIES tagged values. Returns the winning value and its index.
- Used by the fully associative cache for victim selection: largest age counter for LRU, smallest for MRU/LFU-style policies.
- One registered compare-tree level per cycle, valid/ready handshake on both sides, full-pipeline stall under backpressure.

Parameters:
- NUM_ENTRIES, 8, number of candidates; power of 2, at least 2.
- VALUE_WIDTH, 32, width of each candidate value (unsigned).
- INDEX_WIDTH, $clog2(NUM_ENTRIES), width of the returned index; derived, not overridden.

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- values_i  in  NUM_ENTRIES*VALUE_WIDTH  packed candidates; entry k occupies [k*VALUE_WIDTH +: VALUE_WIDTH].
- mask_i  in  NUM_ENTRIES  1 = entry participates; 0 = entry ignored.
- mode_i  in  1  0 = select maximum, 1 = select minimum.
- valid_i  in  1  request valid.
- ready_o  out  1  block can accept a request.
- value_o  out  VALUE_WIDTH  winning value.
- index_o  out  INDEX_WIDTH  winning index.
- found_o  out  1  at least one masked-in entry existed.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts the result.

Behaviour:
- LEVELS = $clog2(NUM_ENTRIES). Stage s (1..LEVELS) registers NUM_ENTRIES>>s nodes, each holding {value, index, present}. mode travels with the request.
- Latency: a request accepted at edge t appears on valid_o after edge t+LEVELS. With no stall, throughput is 1 per cycle.
- Handshake:
  - Accept on valid_i & ready_o.
  - Result is consumed on valid_o & ready_i.
  - ready_o = ~valid_o | ready_i; this is a global stall of all stages.
  - While valid_o & ~ready_i, every stage holds its contents. value_o, index_o and found_o stay stable until consumed.
- Node rule (inputs L = lower-index child, R = higher-index child):
  - Only one present: forward that child.
  - Neither present: forward present=0. Value and index are don't-care, but are driven as L to avoid X propagation.
  - Both present: forward R if R is strictly better (greater in max mode, smaller in min mode), else L.
  - Ties therefore resolve to the lowest index.
- Leaf level: present = mask_i[k], index = k.
- found_o = present of the root. When found_o=0, value_o=0 and index_o=0 (forced at the output).
- Per-stage valid bits shift with the data. A bubble (no accept) propagates valid=0.
- Reset (asynchronous, any cycle, including mid-pipeline): all stage valid bits, valid_o, found_o, value_o and index_o go to 0, so ready_o=1 after reset. In-flight requests are discarded. Data registers may be left unreset except the output stage.
- Comparisons are unsigned, full VALUE_WIDTH; no arithmetic widening is needed.
- Inputs are sampled only on accept; changes to values_i/mask_i while stalled have no effect.

Optional Feature:
- Macro ARGMAX_TREE_TIECOUNT_EN.
- When defined:
  - Adds output tie_count_o, width INDEX_WIDTH+1.
  - Each node also carries a count: if children have equal values and both are present, count = cL + cR. Otherwise count = the count of the forwarded child. A leaf counts 1 if present, 0 if not.
  - tie_count_o equals the number of masked-in entries holding the winning value, and resets to 0.
- When undefined: the port and count logic do not exist; everything else is unchanged.

Decomposition:
- Package argmax_pkg holds:
  - typedef enum logic {ARGMAX_MODE_MAX=1'b0, ARGMAX_MODE_MIN=1'b1} argmax_mode_e;
  - localparam helper function for LEVELS.
- Sub-module argmax_node: combinational compare/select cell with mode, present and tie-break, plus the optional count path. It is instantiated per node via generate loops; argmax_tree owns all registers.

Test Plan:
- N=8, values {3,9,1,9,0,2,7,5}, mask 8'hFF, mode max, ready_i=1 -> 3 cycles later valid_o=1, value_o=9, index_o=1, found_o=1 (tie_count_o=2 if enabled).
- Same values, mode min, mask 8'hEF (entry 4 excluded) -> value_o=1, index_o=2.
- mask 8'h00 -> found_o=0, value_o=0, index_o=0, valid_o=1.
- Issue 5 back-to-back requests, hold ready_i=0 for 4 cycles after the first result -> ready_o=0 during the stall, outputs stable, all 5 results emerge in order with no loss or duplication.
- Deassert reset_n_i asynchronously with 2 requests in flight -> valid_o=0 immediately, ready_o=1 after release, no stale result appears.
- All entries = 32'hFFFF_FFFF, mode max -> index_o=0 (lowest-index tie-break), tie_count_o=8 if enabled.
